// File: rtl/sdram_client_arb.sv
// sdram_client_arb: arbitrates refresh, port A and port B onto one SDRAM controller command port
module sdram_client_arb #(
    parameter int FREQ       = 96_000_000,
    parameter int REFRESH_US = 15
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [22:0] a_addr,
    input  logic [7:0]  a_din,
    output logic        a_ack,
    output logic [7:0]  a_dout,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [22:0] b_addr,
    input  logic [7:0]  b_din,
    output logic        b_ack,
    output logic [7:0]  b_dout,
    output logic        sd_rd,
    output logic        sd_wr,
    output logic        sd_refresh,
    output logic [22:0] sd_addr,
    output logic [7:0]  sd_din,
    input  logic [7:0]  sd_dout,
    input  logic        sd_data_ready,
    input  logic        sd_busy
);
    localparam int REF_CNT = FREQ / 1_000_000 * REFRESH_US - 1;
    localparam int CW      = $clog2(REF_CNT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, SETTLE, WAIT} state_t;
    typedef enum logic [1:0] {SRC_REF, SRC_A, SRC_B} src_t;

    state_t        state;
    src_t          src;
    src_t          nxt_src;
    logic          we;
    logic          nxt_we;
    logic          ref_pending;
    logic [CW-1:0] ref_cnt;
    logic          pick_a;
    logic          pick_b;
    logic          grant;

    always_comb begin
        // a port is masked in its own ack cycle so a req still held by the client cannot re-trigger
        pick_a  = a_req && !a_ack;
        pick_b  = b_req && !b_ack;
        grant   = state == IDLE && !sd_busy && (ref_pending || pick_a || pick_b);
        nxt_src = ref_pending ? SRC_REF : pick_a ? SRC_A : SRC_B;
        nxt_we  = nxt_src == SRC_A ? a_we : nxt_src == SRC_B ? b_we : 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state       <= IDLE;
            src         <= SRC_REF;
            we          <= 1'b0;
            ref_pending <= 1'b0;
            ref_cnt     <= CW'(REF_CNT);
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            sd_refresh  <= 1'b0;
            sd_addr     <= '0;
            sd_din      <= '0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            a_dout      <= '0;
            b_dout      <= '0;
        end else begin
            sd_rd       <= 1'b0;
            sd_wr       <= 1'b0;
            sd_refresh  <= 1'b0;
            a_ack       <= 1'b0;
            b_ack       <= 1'b0;
            ref_cnt     <= ref_cnt == '0 ? CW'(REF_CNT) : ref_cnt - CW'(1);
            // an expiry while a refresh is already pending collapses into that one
            ref_pending <= ref_cnt == '0 || (ref_pending && !(state == ISSUE && sd_refresh));
            case (state)
                IDLE: if (grant) begin
                    state      <= ISSUE;
                    src        <= nxt_src;
                    we         <= nxt_we;
                    sd_rd      <= nxt_src != SRC_REF && !nxt_we;
                    sd_wr      <= nxt_src != SRC_REF && nxt_we;
                    sd_refresh <= nxt_src == SRC_REF;
                    if (nxt_src == SRC_A) begin
                        sd_addr <= a_addr;
                        sd_din  <= a_din;
                    end else if (nxt_src == SRC_B) begin
                        sd_addr <= b_addr;
                        sd_din  <= b_din;
                    end
                end
                ISSUE:  state <= SETTLE;
                SETTLE: state <= WAIT;
                WAIT: begin
                    if (src != SRC_REF && (we ? !sd_busy : sd_data_ready)) begin
                        a_ack <= src == SRC_A;
                        b_ack <= src == SRC_B;
                    end
                    if (src == SRC_A && !we && sd_data_ready) a_dout <= sd_dout;
                    if (src == SRC_B && !we && sd_data_ready) b_dout <= sd_dout;
                    if (!sd_busy) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sdram_client_arb.sv
// tb_sdram_client_arb: scoreboard bench with a small SDRAM controller model behind the arbiter
module tb_sdram_client_arb;
    typedef struct {logic we; logic [22:0] addr; logic [7:0] din;} cmd_t;
    typedef struct {logic we; logic [7:0] d;} rsp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        a_req, a_we, a_ack, b_req, b_we, b_ack;
    logic [22:0] a_addr, b_addr, sd_addr;
    logic [7:0]  a_din, b_din, a_dout, b_dout, sd_din, sd_dout;
    logic        sd_rd, sd_wr, sd_refresh, sd_data_ready, sd_busy;
    logic        force_busy;

    logic [3:0]  m_cnt = '0;
    logic        m_rd = 1'b0;
    logic [22:0] m_addr = '0;
    logic        rst_s = 1'b0;

    int   cyc = 0, n_vec = 0, n_err = 0;
    int   n_cmd = 0, n_ref = 0, n_rw = 0, n_ack = 0;
    int   rd_cyc = 0, fall_cyc = 0;
    logic prev_busy = 1'b1, prev_cmd = 1'b0, prev_a = 1'b0, prev_b = 1'b0;
    logic [7:0] a_hold = '0, b_hold = '0;
    cmd_t exp_cmd[$];
    rsp_t exp_a[$], exp_b[$];
    int   ref_cyc[$], gaps[$];
    cmd_t mc;
    rsp_t mr;

    sdram_client_arb dut (
        .clk(clk), .resetn(resetn),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_din(a_din), .a_ack(a_ack), .a_dout(a_dout),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_din(b_din), .b_ack(b_ack), .b_dout(b_dout),
        .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_refresh(sd_refresh), .sd_addr(sd_addr), .sd_din(sd_din),
        .sd_dout(sd_dout), .sd_data_ready(sd_data_ready), .sd_busy(sd_busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rdat(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'hC2;
    endfunction

    function automatic logic [63:0] outv();
        return 64'({sd_rd, sd_wr, sd_refresh, a_ack, b_ack, sd_addr, sd_din, a_dout, b_dout});
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // controller: busy from the edge after a command, read data 4 cycles after sd_rd
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_s <= resetn;
        if (sd_rd || sd_wr) begin
            m_cnt  <= 4'd4;
            m_rd   <= sd_rd;
            m_addr <= sd_addr;
        end else if (sd_refresh) begin
            m_cnt <= 4'd6;
            m_rd  <= 1'b0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt - 4'd1;
        end
    end
    assign sd_busy       = force_busy || m_cnt != 0;
    assign sd_data_ready = m_rd && m_cnt == 4'd1;
    assign sd_dout       = sd_data_ready ? rdat(m_addr) : 8'hEE;

    always @(negedge clk) begin
        if (!rst_s) begin
            a_hold = '0;
            b_hold = '0;
        end
        if (sd_rd || sd_wr || sd_refresh) begin
            n_cmd++;
            chk("cmd_onehot", int'(sd_rd) + int'(sd_wr) + int'(sd_refresh), 1);
            chk("cmd_1cyc", prev_cmd, 0);
        end
        if (sd_refresh) begin
            n_ref++;
            ref_cyc.push_back(cyc);
        end
        if (sd_rd || sd_wr) begin
            n_rw++;
            gaps.push_back(cyc - fall_cyc);
            if (sd_rd) rd_cyc = cyc;
            if (exp_cmd.size() == 0) chk("cmd_extra", 1, 0);
            else begin
                mc = exp_cmd.pop_front();
                chk("cmd_we", sd_wr, mc.we);
                chk("cmd_addr", sd_addr, mc.addr);
                if (mc.we) chk("cmd_din", sd_din, mc.din);
            end
        end
        if (a_ack) begin
            n_ack++;
            chk("a_ack_1cyc", prev_a, 0);
            if (exp_a.size() == 0) chk("a_ack_extra", 1, 0);
            else begin
                mr = exp_a.pop_front();
                if (mr.we) chk("a_wr_lat", cyc - fall_cyc, 1);
                else begin
                    chk("a_rd_lat", cyc - rd_cyc, 5);
                    a_hold = mr.d;
                end
            end
        end
        if (b_ack) begin
            n_ack++;
            chk("b_ack_1cyc", prev_b, 0);
            if (exp_b.size() == 0) chk("b_ack_extra", 1, 0);
            else begin
                mr = exp_b.pop_front();
                if (mr.we) chk("b_wr_lat", cyc - fall_cyc, 1);
                else begin
                    chk("b_rd_lat", cyc - rd_cyc, 5);
                    b_hold = mr.d;
                end
            end
        end
        chk("a_dout", a_dout, a_hold);
        chk("b_dout", b_dout, b_hold);
        if (prev_busy && !sd_busy) fall_cyc = cyc;
        prev_busy = sd_busy;
        prev_cmd  = sd_rd || sd_wr || sd_refresh;
        prev_a    = a_ack;
        prev_b    = b_ack;
    end

    task automatic exp_push(input logic we, input logic [22:0] addr, input logic [7:0] din);
        exp_cmd.push_back(cmd_t'{we, addr, din});
    endtask

    task automatic xfer(input bit p, input logic we, input logic [22:0] addr, input logic [7:0] din, input int tmo);
        int   n = 0;
        logic got;
        if (p) begin
            exp_b.push_back(rsp_t'{we, rdat(addr)});
            b_req = 1'b1; b_we = we; b_addr = addr; b_din = din;
        end else begin
            exp_a.push_back(rsp_t'{we, rdat(addr)});
            a_req = 1'b1; a_we = we; a_addr = addr; a_din = din;
        end
        do begin
            @(negedge clk);
            n++;
            got = p ? b_ack : a_ack;
        end while (!got && n < tmo);
        if (!got) chk(p ? "b_timeout" : "a_timeout", 0, 1);
        @(negedge clk);
        if (p) b_req = 1'b0;
        else a_req = 1'b0;
    endtask

    initial begin
        int n, rw0, ack0;
        resetn = 1'b0; force_busy = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
        b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
        repeat (5) @(negedge clk);
        chk("reset_outputs", outv(), 0);
        resetn = 1'b1;

        exp_push(1'b0, 23'h000100, 8'h00);
        fork
            xfer(1'b0, 1'b0, 23'h000100, 8'h00, 25000);
            begin
                repeat (20000) @(negedge clk);
                chk("init_quiet", n_cmd, 0);
                force_busy = 1'b0;
            end
        join
        chk("init_one_ref", n_ref, 1);
        chk("init_ref_first", ref_cyc.size() > 0 && ref_cyc[0] < rd_cyc, 1);

        repeat (3) @(negedge clk);
        exp_push(1'b0, 23'h012345, 8'h00);
        xfer(1'b0, 1'b0, 23'h012345, 8'h00, 200);
        repeat (5) @(negedge clk);
        chk("rd_a5_held", a_dout, 8'hA5);
        chk("rd_b_iso", b_dout, 8'h00);

        exp_push(1'b1, 23'h7FFFFF, 8'h3C);
        xfer(1'b1, 1'b1, 23'h7FFFFF, 8'h3C, 200);
        chk("wr_b_dout_kept", b_dout, 8'h00);
        chk("wr_a_dout_kept", a_dout, 8'hA5);

        repeat (3) @(negedge clk);
        exp_push(1'b1, 23'h000777, 8'h5E);
        exp_push(1'b0, 23'h400001, 8'h00);
        rw0 = n_rw;
        gaps.delete();
        fork
            xfer(1'b0, 1'b1, 23'h000777, 8'h5E, 200);
            xfer(1'b1, 1'b0, 23'h400001, 8'h00, 200);
        join
        repeat (10) @(negedge clk);
        chk("cont_rw_count", n_rw - rw0, 2);
        chk("cont_gap", gaps.size() == 2 ? gaps[1] : -1, 2);

        repeat (20) @(negedge clk);
        ref_cyc.delete();
        n = 0;
        while (ref_cyc.size() < 3 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("ref_seen", ref_cyc.size() >= 3, 1);
        if (ref_cyc.size() >= 3) begin
            chk("ref_period1", ref_cyc[1] - ref_cyc[0], 1440);
            chk("ref_period2", ref_cyc[2] - ref_cyc[1], 1440);
        end
        force_busy = 1'b1;
        repeat (3000) @(negedge clk);
        ref_cyc.delete();
        force_busy = 1'b0;
        repeat (30) @(negedge clk);
        chk("ref_once_after_block", ref_cyc.size(), 1);

        exp_push(1'b0, 23'h0000AA, 8'h00);
        a_req = 1'b1; a_we = 1'b0; a_addr = 23'h0000AA;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sd_rd && n < 100);
        chk("rm_rd_seen", sd_rd, 1);
        ack0 = n_ack;
        @(negedge clk);
        resetn = 1'b0; a_req = 1'b0; force_busy = 1'b1;
        @(negedge clk);
        chk("rm_outputs", outv(), 0);
        repeat (20) @(negedge clk);
        chk("rm_still_reset", outv(), 0);
        resetn = 1'b1;
        repeat (30) @(negedge clk);
        chk("rm_no_ack", n_ack - ack0, 0);
        force_busy = 1'b0;

        repeat (3) @(negedge clk);
        exp_push(1'b0, 23'h00ABCD, 8'h00);
        xfer(1'b1, 1'b0, 23'h00ABCD, 8'h00, 200);
        repeat (5) @(negedge clk);
        chk("recover_b_dout", b_dout, 8'hA4);
        chk("cmd_queue_empty", exp_cmd.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
